// File: rtl/io_input_conditioner.sv
// Two-flop synchronisers and counter debouncers for board switches and push-buttons
// feeding the LSU input registers, with one-cycle press / change event strobes.
module io_input_conditioner #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int DB_CYCLES      = 500000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic             o_sw_changed
);

  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [BTN_W-1:0]  BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [SW_W-1:0]  sw_meta, sw_sync, sw_prev;
  logic [BTN_W-1:0] btn_meta, btn_sync, btn_norm, btn_stable;
  logic [CNT_W-1:0] sw_cnt;
  logic [CNT_W-1:0] btn_cnt [BTN_W];

  // Button sync flops idle at the raw "released" level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= BTN_IDLE;
      btn_sync <= BTN_IDLE;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value,
      // giving a true two-flop chain; blocking here would collapse it into one flop.
      sw_meta  <= i_sw_raw;
      sw_sync  <= sw_meta;
      btn_meta <= i_btn_raw;
      btn_sync <= btn_meta;
    end
  end

  assign btn_norm = btn_sync ^ BTN_IDLE;

  // Switch bank: one shared counter, restarted by any change so only the final settled
  // vector is ever published.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_prev      <= '0;
      sw_cnt       <= '0;
      o_io_sw      <= '0;
      o_sw_changed <= 1'b0;
    end else begin
      sw_prev      <= sw_sync;
      o_sw_changed <= 1'b0;
      if (sw_sync == o_io_sw || sw_sync != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt == CNT_LAST) begin
        o_io_sw      <= sw_sync;
        o_sw_changed <= 1'b1;
        sw_cnt       <= '0;
      end else begin
        sw_cnt <= sw_cnt + CNT_ONE;
      end
    end
  end

  // Buttons: independent per-bit debouncers; o_io_btn is a registered copy of the
  // accepted level so the press strobe lines up with its first high cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      btn_stable  <= '0;
      o_io_btn    <= '0;
      o_btn_press <= '0;
      // NOTE: btn_cnt is a small register array, not a RAM; every entry is reset so a
      // count interrupted by reset can never complete afterwards.
      for (int i = 0; i < BTN_W; i++) btn_cnt[i] <= '0;
    end else begin
      o_io_btn    <= btn_stable;
      o_btn_press <= btn_stable & ~o_io_btn;
      for (int i = 0; i < BTN_W; i++) begin
        if (btn_norm[i] == btn_stable[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_LAST) begin
          btn_stable[i] <= btn_norm[i];
          btn_cnt[i]    <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed and randomized bench for io_input_conditioner against a sample-history model
// (DB_CYCLES=8, active-low buttons).
module tb_io_input_conditioner;

  localparam int SW_W  = 32;
  localparam int BTN_W = 4;
  localparam int DB    = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [SW_W-1:0]  i_sw_raw;
  logic [BTN_W-1:0] i_btn_raw;
  logic [SW_W-1:0]  o_io_sw;
  logic [BTN_W-1:0] o_io_btn;
  logic [BTN_W-1:0] o_btn_press;
  logic             o_sw_changed;

  io_input_conditioner #(
    .SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw_raw(i_sw_raw), .i_btn_raw(i_btn_raw),
    .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press),
    .o_sw_changed(o_sw_changed)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Model works on raw samples: a button level is accepted after DB consecutive samples
  // disagreeing with it, a switch vector after DB+1 identical samples; the two-flop
  // synchroniser plus output register then delay what the ports show.
  logic [BTN_W-1:0] acc_btn;
  int               run_btn [BTN_W];
  logic [BTN_W-1:0] btn_hist [5];
  logic [SW_W-1:0]  acc_sw, last_sw;
  int               run_sw;
  logic [SW_W-1:0]  sw_hist [4];

  // Observation tallies for the directed scenarios.
  int press_cnt [BTN_W];
  int chg_cnt;
  int press9_cnt;
  logic seen_a5;
  logic [BTN_W-1:0] btn_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    acc_btn = '0;
    acc_sw  = '0;
    last_sw = '0;
    run_sw  = 0;
    for (int i = 0; i < BTN_W; i++) run_btn[i] = 0;
    for (int j = 0; j < 5; j++) btn_hist[j] = '0;
    for (int j = 0; j < 4; j++) sw_hist[j] = '0;
  endtask

  task automatic model_sample();
    logic [BTN_W-1:0] pressed;
    pressed = ~i_btn_raw;
    for (int i = 0; i < BTN_W; i++) begin
      if (pressed[i] != acc_btn[i]) begin
        run_btn[i]++;
        if (run_btn[i] == DB) begin
          acc_btn[i] = pressed[i];
          run_btn[i] = 0;
        end
      end else begin
        run_btn[i] = 0;
      end
    end
    if (i_sw_raw == last_sw) run_sw++;
    else run_sw = 1;
    last_sw = i_sw_raw;
    if (i_sw_raw != acc_sw && run_sw >= DB + 1) acc_sw = i_sw_raw;
    for (int j = 4; j > 0; j--) btn_hist[j] = btn_hist[j-1];
    btn_hist[0] = acc_btn;
    for (int j = 3; j > 0; j--) sw_hist[j] = sw_hist[j-1];
    sw_hist[0] = acc_sw;
  endtask

  task automatic clear_tallies();
    for (int i = 0; i < BTN_W; i++) press_cnt[i] = 0;
    chg_cnt    = 0;
    press9_cnt = 0;
    seen_a5    = 1'b0;
    btn_seen   = '0;
  endtask

  // One clock: advance the model with what the DUT samples, then compare all outputs.
  task automatic step();
    @(posedge i_clk);
    if (!i_rst) model_reset();
    else model_sample();
    #1;
    check("io_sw",      o_io_sw,              sw_hist[2]);
    check("io_btn",     32'(o_io_btn),        32'(btn_hist[3]));
    check("btn_press",  32'(o_btn_press),     32'(btn_hist[3] & ~btn_hist[4]));
    check("sw_changed", 32'(o_sw_changed),    32'(sw_hist[2] != sw_hist[3]));
    for (int i = 0; i < BTN_W; i++) press_cnt[i] += int'(o_btn_press[i]);
    chg_cnt += int'(o_sw_changed);
    if (o_btn_press == 4'h9) press9_cnt++;
    if (o_io_sw == 32'h0000_00A5) seen_a5 = 1'b1;
    btn_seen |= o_io_btn;
  endtask

  initial begin
    int b;
    // Reset held with active inputs.
    i_rst     = 1'b0;
    i_btn_raw = 4'hF;
    i_sw_raw  = 32'h1234_5678;
    model_reset();
    clear_tallies();
    #1;
    check("rst_io_sw",  o_io_sw,           32'h0);
    check("rst_io_btn", 32'(o_io_btn),     32'h0);
    check("rst_press",  32'(o_btn_press),  32'h0);
    check("rst_chg",    32'(o_sw_changed), 32'h0);
    repeat (3) step();
    i_rst = 1'b1;

    // 1: switches settle to the held vector at cycle 10, buttons stay released.
    clear_tallies();
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 9)  check("t1_sw_c9", o_io_sw, 32'h0);
      if (c == 10) begin
        check("t1_sw_c10",  o_io_sw,           32'h1234_5678);
        check("t1_chg_c10", 32'(o_sw_changed), 32'h1);
      end
    end
    check("t1_chg_count", chg_cnt,        1);
    check("t1_btn_idle",  32'(btn_seen),  32'h0);

    // 2: clean press and release of button 0.
    clear_tallies();
    i_btn_raw = 4'hE;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 9)  check("t2_btn_c9", 32'(o_io_btn), 32'h0);
      if (c == 10) begin
        check("t2_btn_c10",   32'(o_io_btn),    32'h1);
        check("t2_press_c10", 32'(o_btn_press), 32'h1);
      end
      if (c == 11) check("t2_press_c11", 32'(o_btn_press), 32'h0);
    end
    i_btn_raw = 4'hF;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 9)  check("t2_rel_c9",  32'(o_io_btn), 32'h1);
      if (c == 10) check("t2_rel_c10", 32'(o_io_btn), 32'h0);
    end
    check("t2_press_count", press_cnt[0], 1);

    // 3: button 1 bounces every 3 cycles, final edge to pressed at cycle 18.
    clear_tallies();
    for (int c = 0; c < 40; c++) begin
      i_btn_raw[1] = (c < 20) ? logic'((c / 3) % 2) : 1'b0;
      step();
      if (c == 27) check("t3_btn_c27", 32'(o_io_btn[1]), 32'h0);
      if (c == 28) check("t3_btn_c28", 32'(o_io_btn[1]), 32'h1);
    end
    check("t3_press_count", press_cnt[1], 1);
    i_btn_raw = 4'hF;
    repeat (14) step();

    // 4: a 7-cycle glitch on button 2 is never accepted.
    clear_tallies();
    for (int c = 0; c < 22; c++) begin
      i_btn_raw[2] = (c < 7) ? 1'b0 : 1'b1;
      step();
    end
    check("t4_btn_seen",    32'(btn_seen), 32'h0);
    check("t4_press_count", press_cnt[2],  0);

    // 5: switch bank bounces 0 -> A5 -> 1A5 and publishes only the final vector.
    i_sw_raw = 32'h0;
    repeat (14) step();
    clear_tallies();
    for (int c = 0; c < 22; c++) begin
      i_sw_raw = (c < 5) ? 32'h0000_00A5 : 32'h0000_01A5;
      step();
      if (c == 14) check("t5_sw_c14", o_io_sw, 32'h0);
      if (c == 15) check("t5_sw_c15", o_io_sw, 32'h0000_01A5);
    end
    check("t5_chg_count", chg_cnt,        1);
    check("t5_no_a5",     32'(seen_a5),   32'h0);

    // 6: simultaneous press of buttons 0 and 3.
    clear_tallies();
    i_btn_raw = 4'h6;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 10) check("t6_press_c10", 32'(o_btn_press), 32'h9);
    end
    check("t6_press9_count", press9_cnt, 1);
    i_btn_raw = 4'hF;
    repeat (14) step();

    // 6b: same press interrupted by reset during the count.
    clear_tallies();
    i_btn_raw = 4'h6;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) i_rst = 1'b0;
      if (c == 6) i_rst = 1'b1;
      step();
      if (c == 5)  check("t6b_rst_btn", 32'(o_io_btn), 32'h0);
      if (c == 15) check("t6b_btn_c15", 32'(o_io_btn), 32'h0);
      if (c == 16) check("t6b_btn_c16", 32'(o_io_btn), 32'h9);
    end
    check("t6b_press9_count", press9_cnt, 1);

    // Randomized activity with occasional resets, compared cycle by cycle.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = int'($urandom_range(0, BTN_W - 1));
        i_btn_raw[b] = ~i_btn_raw[b];
      end
      if ($urandom_range(0, 14) == 0)
        i_sw_raw = i_sw_raw ^ (32'h1 << $urandom_range(0, SW_W - 1));
      if ($urandom_range(0, 199) == 0) begin
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
